mux_2x1_arb: RTL
================

# mux_2x1_arb

Two-requester round-robin arbiter and sequencer for the 2:1 mux datapath. Each requester presents a valid/last stream. The block grants one requester at a time, drives the mux select, and registers the selected beat into a single output stage with a ready/valid handshake toward the downstream consumer. It sits between two producer streams and one shared consumer and is the only block that drives the mux select.

## Interface
- WIDTH, 8, data width of each stream; the datapath is WIDTH instances of mux_2x1, one per bit.
- clk_in  input  1  single clock; all logic rising-edge.
- rst_in  input  1  reset, synchronous, active-high.
- req_in  input  2  per-requester beat valid; bit i belongs to requester i.
- last_in  input  2  per-requester end-of-packet flag, qualified by req_in[i].
- data0_in  input  WIDTH  requester 0 data.
- data1_in  input  WIDTH  requester 1 data.
- gnt_out  output  2  per-requester accept (ready); a beat transfers when req_in[i] && gnt_out[i].
- sel_out  output  1  mux select; 1 = requester 1.
- d_out  output  WIDTH  registered output data.
- valid_out  output  1  output stage holds a beat.
- last_out  output  1  registered last flag of the held beat.
- ready_in  input  1  downstream accept; an output beat retires when valid_out && ready_in.

## Operation
- State machine:
  - IDLE: no grant held.
  - GNT0: requester 0 granted.
  - GNT1: requester 1 granted.
- Priority pointer `prio` (1 bit) names the preferred requester when both request.
- Arbitration runs in IDLE, and in the same cycle as a packet-ending accept:
  - Both requesting: grant `prio`.
  - One requesting: grant that one.
  - None requesting: go to IDLE.
- A packet ends on an accepted beat with last_in[i]=1. On packet end, `prio` <= ~i.
- `space` = !valid_out || ready_in.
- gnt_out[i] = (state==GNTi) && space. This is combinational from state, valid_out and ready_in; it never depends on req_in.
- sel_out = (state==GNT1). In IDLE sel_out is 0.
- On accept, the output register loads:
  - d_out <= selected data.
  - last_out <= last_in[i].
  - valid_out <= 1.
- Without an accept: if ready_in && valid_out, valid_out <= 0. Otherwise the output register holds.
- A requester must hold req_in until its last beat is accepted. If req_in[i] drops mid-packet, the block stays in GNTi indefinitely; the other requester waits.
- Data from the non-granted requester never reaches d_out.

## Timing
- Reset: state=IDLE, prio=0, gnt_out=00, sel_out=0, valid_out=0, last_out=0, d_out=0.
- IDLE with a request at cycle N: state=GNTi at N+1, and the first accept is possible at N+1.
- Latency from accept at cycle N to valid_out=1 with that data is one cycle (N+1).
- Throughput is one beat per cycle while ready_in=1. The packet-to-packet switch is bubble-free when the next winner is requesting during the last-beat cycle.
- Backpressure: with valid_out=1 and ready_in=0, gnt_out=00, and d_out/last_out are stable.
- Simultaneous retire and accept in the same cycle: the new beat loads and valid_out stays 1.
- Reset asserted mid-packet: the next edge forces reset values and any in-flight beat is dropped.
- Requests arriving in the same cycle the grant changes are evaluated only at the next arbitration point.

## Configuration
- MUX_2X1_ARB_PKT_LOCK_EN defined:
  - The grant is held for a whole packet, from grant until the accepted beat with last_in=1.
- MUX_2X1_ARB_PKT_LOCK_EN undefined:
  - Every accepted beat is treated as packet end for arbitration, so both requesters alternate beat by beat.
  - last_in is still registered to last_out unchanged.

## Test plan
- Reset: hold rst_in 2 cycles with req_in=11 -> all outputs 0. First grant after release goes to requester 0 (gnt_out=01, sel_out=0).
- Lock on: req 0 sends 3 beats A0..A2 (last on A2) while req 1 holds B0 valid, ready_in=1 -> d_out sequence A0,A1,A2,B0 on consecutive cycles, no bubble, sel_out=1 during the B0 accept cycle.
- Lock off, both streaming, ready_in=1 -> accepted order alternates 0,1,0,1; prio toggles every beat.
- Backpressure: valid_out=1 with d_out=0x5A, ready_in=0 for 4 cycles -> gnt_out=00, d_out stays 0x5A. After ready_in=1, the next beat appears one cycle later.
- Single requester: only req_in[1] active, 1-beat packets -> gnt_out=10 every cycle, one beat per cycle; state never revisits IDLE while requests continue.
- Reset mid-packet: assert rst_in during beat 2 of a 4-beat packet -> valid_out=0 and state=IDLE next cycle; after release requester 0 wins, since prio=0.

Source files
------------

// File: rtl/mux_2x1_arb.sv
// Two-requester round-robin arbiter driving a per-bit 2:1 mux into a registered ready/valid output stage.
// Optional packet locking is enabled with `define MUX_2X1_ARB_PKT_LOCK_EN.

module mux_2x1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module mux_2x1_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [1:0]       req_in,
  input  logic [1:0]       last_in,
  input  logic [WIDTH-1:0] data0_in,
  input  logic [WIDTH-1:0] data1_in,
  output logic [1:0]       gnt_out,
  output logic             sel_out,
  output logic [WIDTH-1:0] d_out,
  output logic             valid_out,
  output logic             last_out,
  input  logic             ready_in
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             space;
  logic             sel;
  logic [1:0]       gnt;
  logic             accept;
  logic             cur_last;
  logic             pkt_end;
  logic [WIDTH-1:0] mux_y;

  assign space    = !valid_q || ready_in;
  assign sel      = (state_q == GNT1);
  assign gnt      = {(state_q == GNT1) && space, (state_q == GNT0) && space};
  assign accept   = |(gnt & req_in);
  assign cur_last = sel ? last_in[1] : last_in[0];

`ifdef MUX_2X1_ARB_PKT_LOCK_EN
  assign pkt_end = accept && cur_last;
`else
  // Every accepted beat closes an arbitration round, so requesters alternate per beat.
  assign pkt_end = accept;
`endif

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux_2x1 u_mux (
        .a_i  (data0_in[gi]),
        .b_i  (data1_in[gi]),
        .sel_i(sel),
        .y_o  (mux_y[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    d_d     = d_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (accept) begin
      d_d     = mux_y;
      last_d  = cur_last;
      valid_d = 1'b1;
    end else if (ready_in && valid_q) begin
      valid_d = 1'b0;
    end

    if (pkt_end) begin
      prio_d = ~sel;
    end

    // Arbitration uses the already-updated priority so the other side wins on a tie.
    if ((state_q == IDLE) || pkt_end) begin
      unique case (req_in)
        2'b11:   state_d = prio_d ? GNT1 : GNT0;
        2'b01:   state_d = GNT0;
        2'b10:   state_d = GNT1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      d_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign gnt_out   = gnt;
  assign sel_out   = sel;
  assign d_out     = d_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;

endmodule
